// File: rtl/nat_pkg.sv
// rtl/nat_pkg.sv - shared constants and tuple layout for the NAT stages
package nat_pkg;

  localparam int          HASH_LEN   = 10;
  localparam int          CONN_SPACE = 1 << HASH_LEN;
  localparam int          WIDTH      = 104;
  localparam logic [15:0] ETHERTYPE  = 16'h0900;
  localparam logic [7:0]  PROTO_TCP  = 8'h06;

  localparam int T_SRC_IP_LSB   = 72;
  localparam int T_DST_IP_LSB   = 40;
  localparam int T_SRC_PORT_LSB = 24;
  localparam int T_DST_PORT_LSB = 8;
  localparam int T_PROTO_LSB    = 0;

  localparam logic [2:0] W_ETH   = 3'd1;
  localparam logic [2:0] W_PROTO = 3'd2;
  localparam logic [2:0] W_IP    = 3'd3;
  localparam logic [2:0] W_PORT  = 3'd4;

  typedef enum logic [2:0] {
    ST_PASS,
    ST_HOLD3,
    ST_LOOKUP,
    ST_EMIT3,
    ST_EMIT4
  } state_e;

endpackage

// File: rtl/nat_conn_table.sv
// rtl/nat_conn_table.sv - connection table: one write port, one registered read port
module nat_conn_table
  import nat_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [HASH_LEN-1:0] wr_idx,
  input  logic [WIDTH-1:0]    wr_tuple,
  input  logic                rd_en,
  input  logic [HASH_LEN-1:0] rd_idx,
  output logic [WIDTH-1:0]    rd_tuple,
  output logic                rd_valid
);

  logic [WIDTH-1:0]      mem_q [CONN_SPACE];
  logic [WIDTH-1:0]      rd_tuple_q;
  logic [CONN_SPACE-1:0] valid_q, valid_d;
  logic                  rd_valid_q, rd_valid_d;

  always_comb begin
    valid_d    = valid_q;
    rd_valid_d = rd_valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
    if (rd_en) rd_valid_d = valid_q[rd_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Read samples the pre-write contents, so a same-cycle learn is seen only by later lookups.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_tuple;
    if (rd_en) rd_tuple_q <= mem_q[rd_idx];
  end

  assign rd_tuple = rd_tuple_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/nat_inbound_restore.sv
// rtl/nat_inbound_restore.sv - inbound NAT stage restoring client dst_ip/dst_port on custom-IP TCP replies
module nat_inbound_restore
  import nat_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [63:0]         s_axis_tdata,
  input  logic [7:0]          s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [63:0]         m_axis_tdata,
  output logic [7:0]          m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  input  logic                learn_valid,
  input  logic [HASH_LEN-1:0] learn_idx,
  input  logic [WIDTH-1:0]    learn_tuple,
  output logic [31:0]         miss_cnt
);

  state_e              state_q, state_d;
  logic [2:0]          beat_q, beat_d;
  logic                eth_q, eth_d, elig_q, elig_d;
  logic [63:0]         h3_data_q, h3_data_d, h4_data_q, h4_data_d;
  logic [7:0]          h3_keep_q, h3_keep_d, h4_keep_q, h4_keep_d;
  logic                h4_last_q, h4_last_d, skip_q, skip_d;
  logic [HASH_LEN-1:0] idx_q, idx_d;
  logic                out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [63:0]         out_data_q, out_data_d;
  logic [7:0]          out_keep_q, out_keep_d;
  logic [31:0]         miss_q, miss_d;

  logic                out_free, s_ready, s_fire, hit, rd_valid;
  logic [WIDTH-1:0]    rd_tuple;
  logic [31:0]         e_src_ip, e_dst_ip;
  logic [15:0]         e_src_port, e_dst_port;
  logic [7:0]          e_proto;

  nat_conn_table u_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (learn_valid),
    .wr_idx   (learn_idx),
    .wr_tuple (learn_tuple),
    .rd_en    (state_q == ST_LOOKUP),
    .rd_idx   (idx_q),
    .rd_tuple (rd_tuple),
    .rd_valid (rd_valid)
  );

  assign e_src_ip   = rd_tuple[T_SRC_IP_LSB +: 32];
  assign e_dst_ip   = rd_tuple[T_DST_IP_LSB +: 32];
  assign e_src_port = rd_tuple[T_SRC_PORT_LSB +: 16];
  assign e_dst_port = rd_tuple[T_DST_PORT_LSB +: 16];
  assign e_proto    = rd_tuple[T_PROTO_LSB +: 8];

  assign out_free = !out_valid_q || m_axis_tready;
  assign s_ready  = ((state_q == ST_PASS) || (state_q == ST_HOLD3)) && out_free;
  assign s_fire   = s_axis_tvalid && s_ready;
  // The reply's source is the server, which is what the outbound stage stored as dst.
  assign hit = !skip_q && rd_valid && (e_dst_ip == h3_data_q[47:16]) &&
               (e_dst_port == h4_data_q[31:16]) && (e_proto == PROTO_TCP);

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    eth_d       = eth_q;
    elig_d      = elig_q;
    h3_data_d   = h3_data_q;
    h3_keep_d   = h3_keep_q;
    h4_data_d   = h4_data_q;
    h4_keep_d   = h4_keep_q;
    h4_last_d   = h4_last_q;
    skip_d      = skip_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    miss_d      = miss_q;

    if (out_valid_q && m_axis_tready) out_valid_d = 1'b0;

    if (s_fire) begin
      beat_d = s_axis_tlast ? 3'd0 : ((beat_q == 3'd7) ? beat_q : beat_q + 3'd1);
      if (beat_q == W_ETH)
        eth_d = (s_axis_tdata[39:32] == ETHERTYPE[15:8]) && (s_axis_tdata[47:40] == ETHERTYPE[7:0]);
      if (beat_q == W_PROTO) elig_d = eth_q && (s_axis_tdata[63:56] == PROTO_TCP);
      if (s_axis_tlast) begin
        eth_d  = 1'b0;
        elig_d = 1'b0;
      end
    end

    case (state_q)
      ST_PASS: if (s_fire) begin
        if ((beat_q == W_IP) && elig_q && !s_axis_tlast) begin
          h3_data_d = s_axis_tdata;
          h3_keep_d = s_axis_tkeep;
          state_d   = ST_HOLD3;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = s_axis_tdata;
          out_keep_d  = s_axis_tkeep;
          out_last_d  = s_axis_tlast;
        end
      end
      ST_HOLD3: if (s_fire) begin
        h4_data_d = s_axis_tdata;
        h4_keep_d = s_axis_tkeep;
        h4_last_d = s_axis_tlast;
        idx_d     = {s_axis_tdata[32+HASH_LEN-9:32], s_axis_tdata[47:40]};
        skip_d    = s_axis_tlast;
        state_d   = s_axis_tlast ? ST_EMIT3 : ST_LOOKUP;
      end
      ST_LOOKUP: state_d = ST_EMIT3;
      ST_EMIT3: if (out_free) begin
        out_valid_d = 1'b1;
        out_data_d  = h3_data_q;
        out_keep_d  = h3_keep_q;
        out_last_d  = 1'b0;
        if (hit) out_data_d[63:48] = e_src_ip[15:0];
        state_d = ST_EMIT4;
      end
      ST_EMIT4: if (out_free) begin
        out_valid_d = 1'b1;
        out_data_d  = h4_data_q;
        out_keep_d  = h4_keep_q;
        out_last_d  = h4_last_q;
        if (hit) begin
          out_data_d[15:0]  = e_src_ip[31:16];
          out_data_d[47:32] = e_src_port;
        end else if (!skip_q && (miss_q != 32'hFFFF_FFFF)) begin
          miss_d = miss_q + 32'd1;
        end
        state_d = ST_PASS;
      end
      default: state_d = ST_PASS;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_PASS;
      beat_q      <= 3'd0;
      eth_q       <= 1'b0;
      elig_q      <= 1'b0;
      h3_data_q   <= '0;
      h3_keep_q   <= '0;
      h4_data_q   <= '0;
      h4_keep_q   <= '0;
      h4_last_q   <= 1'b0;
      skip_q      <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      eth_q       <= eth_d;
      elig_q      <= elig_d;
      h3_data_q   <= h3_data_d;
      h3_keep_q   <= h3_keep_d;
      h4_data_q   <= h4_data_d;
      h4_keep_q   <= h4_keep_d;
      h4_last_q   <= h4_last_d;
      skip_q      <= skip_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      miss_q      <= miss_d;
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;
  assign miss_cnt      = miss_q;

endmodule

// File: tb/tb_nat_inbound_restore.sv
// tb/tb_nat_inbound_restore.sv - directed and randomized checks of nat_inbound_restore against a packet-level model
module tb_nat_inbound_restore;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [63:0]   s_axis_tdata = '0;
  logic [7:0]    s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          learn_valid = 1'b0;
  logic [9:0]    learn_idx = '0;
  logic [103:0]  learn_tuple = '0;
  logic [31:0]   miss_cnt;

  always #5 clk = ~clk;

  nat_inbound_restore dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .learn_valid(learn_valid), .learn_idx(learn_idx), .learn_tuple(learn_tuple),
    .miss_cnt(miss_cnt)
  );

  int           checks = 0;
  int           errors = 0;
  int           stalls;
  int           got_base;
  bit           drv_done;
  logic [31:0]  exp_miss = '0;
  logic [63:0]  pkt_data[$];
  logic [7:0]   pkt_keep[$];
  logic [63:0]  exp_data[$];
  logic [7:0]   exp_keep[$];
  logic [63:0]  got_data[$];
  logic [7:0]   got_keep[$];
  bit           got_last[$];
  bit           tab_valid[1024];
  logic [103:0] tab_tuple[1024];
  logic [9:0]   coll_idx;
  logic [103:0] coll_tuple;
  logic [9:0]   pool[4];

  always @(negedge clk)
    if (!reset && m_axis_tvalid && m_axis_tready) begin
      got_data.push_back(m_axis_tdata);
      got_keep.push_back(m_axis_tkeep);
      got_last.push_back(m_axis_tlast);
    end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 1024; i++) tab_valid[i] = 1'b0;
    exp_miss = '0;
  endtask

  task automatic learn(input logic [9:0] idx, input logic [103:0] t);
    learn_idx = idx;
    learn_tuple = t;
    learn_valid = 1'b1;
    @(posedge clk);
    #1 learn_valid = 1'b0;
    tab_valid[idx] = 1'b1;
    tab_tuple[idx] = t;
  endtask

  task automatic gen_reply(input logic [31:0] sip, input logic [15:0] sport, input logic [9:0] idx,
                           input logic [15:0] etype, input logic [7:0] proto, input int len);
    logic [63:0] d;
    pkt_data.delete();
    pkt_keep.delete();
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom};
      if (i == 1) begin d[39:32] = etype[15:8]; d[47:40] = etype[7:0]; end
      if (i == 2) d[63:56] = proto;
      if (i == 3) d[47:16] = sip;
      if (i == 4) begin d[31:16] = sport; d[47:40] = idx[7:0]; d[33:32] = idx[9:8]; end
      pkt_data.push_back(d);
      pkt_keep.push_back((i == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF);
    end
  endtask

  // Packet-level reference: 0 = passthrough, 1 = eligible but too short, 2 = restore attempted.
  function automatic int model_pkt();
    int n;
    logic [63:0] w1, w2, w3, w4;
    logic [9:0] idx;
    logic [103:0] e;
    bit elig, hit;
    n = pkt_data.size();
    exp_data = pkt_data;
    exp_keep = pkt_keep;
    elig = 1'b0;
    if (n >= 3) begin
      w1 = pkt_data[1];
      w2 = pkt_data[2];
      elig = ({w1[39:32], w1[47:40]} == 16'h0900) && (w2[63:56] == 8'h06);
    end
    if (!elig) return 0;
    if (n < 6) return 1;
    w3 = pkt_data[3];
    w4 = pkt_data[4];
    idx = {w4[33:32], w4[47:40]};
    e = tab_tuple[idx];
    hit = tab_valid[idx] && (e[71:40] == w3[47:16]) && (e[23:8] == w4[31:16]) && (e[7:0] == 8'h06);
    if (hit) begin
      w3[63:48] = e[87:72];
      w4[15:0]  = e[103:88];
      w4[47:32] = e[39:24];
      exp_data[3] = w3;
      exp_data[4] = w4;
    end else if (exp_miss != 32'hFFFF_FFFF) begin
      exp_miss = exp_miss + 1;
    end
    return 2;
  endfunction

  task automatic drive_pkt(input int nb, input bit with_last);
    for (int i = 0; i < nb; i++) begin
      bit acc;
      int guard;
      s_axis_tdata  = pkt_data[i];
      s_axis_tkeep  = pkt_keep[i];
      s_axis_tlast  = with_last && (i == pkt_data.size() - 1);
      s_axis_tvalid = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 200) begin
        @(negedge clk);
        acc = s_axis_tready;
        if (!acc) stalls++;
        @(posedge clk);
        #1 guard++;
      end
      if (!acc) check("accept_timeout", 0, 1);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // mode: 0 plain, 1 downstream stall over EMIT3, 2 random backpressure, 3 learn during LOOKUP
  task automatic run_pkt(input string tag, input int mode);
    int kind, guard;
    logic [72:0] gb, eb;
    kind = model_pkt();
    got_base = got_data.size();
    stalls = 0;
    drv_done = 1'b0;
    fork
      begin
        drive_pkt(pkt_data.size(), 1'b1);
        drv_done = 1'b1;
      end
      begin
        int pg;
        pg = 0;
        if (mode == 1 || mode == 3)
          while (stalls == 0 && pg < 3000) begin #1 pg++; end
        if (mode == 1 && stalls != 0) begin
          @(posedge clk);
          #1 m_axis_tready = 1'b0;
          repeat (4) @(posedge clk);
          #1 m_axis_tready = 1'b1;
        end else if (mode == 3 && stalls != 0) begin
          learn(coll_idx, coll_tuple);
        end else if (mode == 2) begin
          while (!drv_done) begin
            @(posedge clk);
            #1 m_axis_tready = ($urandom_range(0, 2) != 0);
          end
        end
      end
    join
    m_axis_tready = 1'b1;
    guard = 0;
    while ((got_data.size() - got_base) < exp_data.size() && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_count"}, got_data.size() - got_base, exp_data.size());
    for (int i = 0; i < exp_data.size(); i++)
      if (got_base + i < got_data.size()) begin
        gb = {got_data[got_base + i], got_keep[got_base + i], got_last[got_base + i]};
        eb = {exp_data[i], exp_keep[i], (i == exp_data.size() - 1)};
        check($sformatf("%s_beat%0d", tag, i), gb, eb);
      end
    check({tag, "_miss"}, miss_cnt, exp_miss);
    if (mode == 0 && kind != 1) check({tag, "_stalls"}, stalls, (kind == 2) ? 3 : 0);
  endtask

  initial begin
    logic [63:0] w;
    logic [9:0] ridx;
    logic [31:0] sip;
    logic [15:0] sport;
    int r;

    pool[0] = 10'd5; pool[1] = 10'd7; pool[2] = 10'd1023; pool[3] = 10'd512;
    @(posedge clk);
    #1;
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_m_tkeep", m_axis_tkeep, 0);
    check("rst_s_tready", s_axis_tready, 1);
    check("rst_miss", miss_cnt, 0);
    do_reset();

    learn(10'd5, {32'h0A000001, 32'h08080808, 16'd1234, 16'd80, 8'h06});
    gen_reply(32'h08080808, 16'd80, 10'd5, 16'h0900, 8'h06, 7);
    run_pkt("hit5", 0);
    w = got_data[got_base + 3];
    check("hit5_w3_dstip_lo", w[63:48], 16'h0001);
    w = got_data[got_base + 4];
    check("hit5_w4_dstip_hi", w[15:0], 16'h0A00);
    check("hit5_w4_dstport", w[47:32], 16'd1234);

    do_reset();
    gen_reply(32'h08080808, 16'd80, 10'd5, 16'h0900, 8'h06, 7);
    run_pkt("nolearn", 0);
    check("nolearn_miss1", miss_cnt, 1);

    learn(10'd5, {32'h0A000001, 32'h08080808, 16'd1234, 16'd80, 8'h06});
    gen_reply(32'h08080808, 16'd81, 10'd5, 16'h0900, 8'h06, 7);
    run_pkt("port81", 0);

    gen_reply(32'h08080808, 16'd80, 10'd5, 16'h0800, 8'h06, 7);
    run_pkt("eth0800", 0);
    gen_reply(32'h08080808, 16'd80, 10'd5, 16'h0900, 8'd17, 7);
    run_pkt("udp", 0);

    gen_reply(32'h08080808, 16'd80, 10'd5, 16'h0900, 8'h06, 8);
    run_pkt("bp_emit3", 1);

    learn(10'd7, {32'hC0A80002, 32'h01020304, 16'd5555, 16'd443, 8'h06});
    coll_idx = 10'd7;
    coll_tuple = {32'hC0A80003, 32'h01020304, 16'd6666, 16'd444, 8'h06};
    gen_reply(32'h01020304, 16'd443, 10'd7, 16'h0900, 8'h06, 6);
    run_pkt("coll_old", 3);
    gen_reply(32'h01020304, 16'd443, 10'd7, 16'h0900, 8'h06, 6);
    run_pkt("coll_new", 0);

    for (int len = 3; len <= 5; len++) begin
      gen_reply(32'h08080808, 16'd80, 10'd5, 16'h0900, 8'h06, len);
      run_pkt($sformatf("short%0d", len), 0);
    end

    gen_reply(32'h08080808, 16'd80, 10'd5, 16'h0900, 8'h06, 7);
    got_base = got_data.size();
    drive_pkt(4, 1'b0);
    do_reset();
    check("midrst_m_tvalid", m_axis_tvalid, 0);
    check("midrst_s_tready", s_axis_tready, 1);
    check("midrst_miss", miss_cnt, 0);
    learn(10'd1023, {32'hAC100005, 32'h5DB8D822, 16'd40000, 16'd8443, 8'h06});
    gen_reply(32'h5DB8D822, 16'd8443, 10'd1023, 16'h0900, 8'h06, 6);
    run_pkt("idx1023", 0);
    w = got_data[got_base + 4];
    check("idx1023_dstport", w[47:32], 16'd40000);
    gen_reply(32'h08080808, 16'd80, 10'd5, 16'h0900, 8'h06, 6);
    run_pkt("cleared5", 0);

    for (int p = 0; p < 30; p++) begin
      r = $urandom_range(0, 9);
      ridx = ($urandom_range(0, 3) == 0) ? 10'($urandom) : pool[$urandom_range(0, 3)];
      if (r < 3)
        learn(ridx, {$urandom, $urandom, 16'($urandom), 16'($urandom),
                     ($urandom_range(0, 7) == 0) ? 8'd17 : 8'h06});
      sip = $urandom;
      sport = 16'($urandom);
      if (tab_valid[ridx] && $urandom_range(0, 3) != 0) begin
        sip = tab_tuple[ridx][71:40];
        sport = tab_tuple[ridx][23:8];
      end
      gen_reply(sip, sport, ridx, ($urandom_range(0, 4) == 0) ? 16'h0800 : 16'h0900,
                ($urandom_range(0, 4) == 0) ? 8'd17 : 8'h06, $urandom_range(1, 8));
      run_pkt($sformatf("rnd%0d", p), ($urandom_range(0, 1) == 0) ? 0 : 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
